// File: rtl/branch_predictor_table_ctrl.sv
// branch_predictor_table_ctrl: table of 2-bit saturating branch predictors with a retiring update queue
//
// Ports:
//   clk, reset         clock; synchronous active-high reset (restarts table init, drops queued updates)
//   lookup_valid/idx   fetch-side lookup request
//   predict_valid      registered response flag for the previous-cycle lookup
//   predict            predicted direction (counter MSB)
//   predict_state      raw 2-bit counter returned by the lookup (held while predict_valid=0)
//   upd_valid/idx/taken resolved branch outcome from execute
//   upd_ready          queue can accept an outcome this cycle (run state and not full)
//   q_count            outcomes queued but not yet written to the table
//   init_done          table initialisation has completed
//
// Build option: define BPT_BYPASS_EN so that a lookup hitting the entry being
// retired in the same cycle returns the post-update counter value.
module branch_predictor_table_ctrl #(
    parameter int          IDX_W      = 4,
    parameter int          QDEPTH     = 4,
    parameter logic [1:0]  INIT_STATE = 2'b10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         lookup_valid,
    input  logic [IDX_W-1:0]             lookup_idx,
    output logic                         predict_valid,
    output logic                         predict,
    output logic [1:0]                   predict_state,
    input  logic                         upd_valid,
    input  logic [IDX_W-1:0]             upd_idx,
    input  logic                         upd_taken,
    output logic                         upd_ready,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count,
    output logic                         init_done
);
    localparam int N  = 1 << IDX_W;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             predict_valid_q, predict_valid_d;
    logic [1:0]       predict_state_q, predict_state_d;
    logic             init_done_q, init_done_d;

    logic [1:0]       table_q [N];
    logic [IDX_W-1:0] q_idx_q [QDEPTH];
    logic             q_taken_q [QDEPTH];

    logic             run, push, pop, wr_en;
    logic [IDX_W-1:0] head_idx, wr_idx;
    logic [1:0]       head_old, head_new, wr_data, rd_val;

    assign run           = (state_q == S_RUN);
    assign upd_ready     = run && (count_q < CW'(QDEPTH));
    assign predict_valid = predict_valid_q;
    assign predict_state = predict_state_q;
    assign predict       = predict_state_q[1];
    assign q_count       = count_q;
    assign init_done     = init_done_q;

    // Retiring head: read-modify-write of the current table value, so
    // back-to-back updates to one index accumulate rather than overwrite.
    assign head_idx = q_idx_q[rd_ptr_q];
    assign head_old = table_q[head_idx];
    assign head_new = q_taken_q[rd_ptr_q] ? ((head_old == 2'b11) ? head_old : head_old + 2'd1)
                                          : ((head_old == 2'b00) ? head_old : head_old - 2'd1);

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        init_done_d     = init_done_q;
        wr_en           = 1'b0;
        wr_idx          = ptr_q;
        wr_data         = INIT_STATE;
        push            = 1'b0;
        pop             = 1'b0;
        predict_valid_d = 1'b0;
        predict_state_d = predict_state_q;
        rd_val          = table_q[lookup_idx];
        if (state_q == S_INIT) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + IDX_W'(1);
            if (ptr_q == IDX_W'(N - 1)) begin
                state_d     = S_RUN;
                init_done_d = 1'b1;
            end
        end else begin
            push    = upd_valid && upd_ready;
            pop     = (count_q != '0);
            wr_en   = pop;
            wr_idx  = head_idx;
            wr_data = head_new;
`ifdef BPT_BYPASS_EN
            rd_val  = (pop && head_idx == lookup_idx) ? head_new : table_q[lookup_idx];
`endif
            predict_valid_d = lookup_valid;
            predict_state_d = lookup_valid ? rd_val : predict_state_q;
        end
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? ((wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? ((rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_INIT;
            ptr_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            predict_valid_q <= 1'b0;
            predict_state_q <= 2'b00;
            init_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            predict_valid_q <= predict_valid_d;
            predict_state_q <= predict_state_d;
            init_done_q     <= init_done_d;
        end
    end

    // Storage arrays carry no reset: the table is rewritten by INIT and queue
    // slots are only read after being pushed.
    always_ff @(posedge clk) begin
        if (wr_en && !reset)
            table_q[wr_idx] <= wr_data;
        if (push && !reset) begin
            q_idx_q[wr_ptr_q]   <= upd_idx;
            q_taken_q[wr_ptr_q] <= upd_taken;
        end
    end
endmodule

// File: tb/tb_branch_predictor_table_ctrl.sv
// tb_branch_predictor_table_ctrl: directed and random checks against a queue/array reference model
module tb_branch_predictor_table_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lookup_valid = 1'b0;
    logic [3:0] lookup_idx = '0;
    logic       predict_valid, predict;
    logic [1:0] predict_state;
    logic       upd_valid = 1'b0;
    logic [3:0] upd_idx = '0;
    logic       upd_taken = 1'b0;
    logic       upd_ready;
    logic [2:0] q_count;
    logic       init_done;

    int tests = 0;
    int fails = 0;

    logic [1:0] m_tab [16];
    logic [3:0] mq_idx [$];
    logic       mq_tk [$];
    bit         m_run = 1'b0;
    int         m_cnt = 0;
    logic       m_pv = 1'b0;
    logic [1:0] m_ps = 2'b00;

    branch_predictor_table_ctrl dut (
        .clk(clk), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
        .predict_valid(predict_valid), .predict(predict), .predict_state(predict_state),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_ready(upd_ready), .q_count(q_count), .init_done(init_done)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] sat(input logic [1:0] v, input logic t);
        int x = int'(v) + (t ? 1 : -1);
        return logic'(0) ? 2'b00 : 2'(x < 0 ? 0 : (x > 3 ? 3 : x));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational ready, advance the
    // model by the behavioural rules, then check the registered outputs.
    task automatic step(input logic rs, input logic lv, input logic [3:0] li,
                        input logic uv, input logic [3:0] ui, input logic ut);
        logic       ready, push, pop;
        logic [1:0] val;
        reset = rs; lookup_valid = lv; lookup_idx = li;
        upd_valid = uv; upd_idx = ui; upd_taken = ut;
        ready = m_run && mq_idx.size() < 4;
        #1;
        check("upd_ready", 32'(upd_ready), 32'(ready));
        @(posedge clk);
        if (rs) begin
            m_run = 1'b0; m_cnt = 0; m_pv = 1'b0; m_ps = 2'b00;
            mq_idx.delete(); mq_tk.delete();
        end else if (!m_run) begin
            m_pv = 1'b0;
            m_cnt++;
            if (m_cnt == 16) begin
                m_run = 1'b1;
                foreach (m_tab[i]) m_tab[i] = 2'b10;
            end
        end else begin
            push = uv && ready;
            pop  = mq_idx.size() > 0;
            m_pv = lv;
            if (lv) begin
                val = m_tab[li];
`ifdef BPT_BYPASS_EN
                if (pop && mq_idx[0] == li) val = sat(m_tab[li], mq_tk[0]);
`endif
                m_ps = val;
            end
            if (pop) begin
                m_tab[mq_idx[0]] = sat(m_tab[mq_idx[0]], mq_tk[0]);
                void'(mq_idx.pop_front());
                void'(mq_tk.pop_front());
            end
            if (push) begin
                mq_idx.push_back(ui);
                mq_tk.push_back(ut);
            end
        end
        #1;
        check("predict_valid", 32'(predict_valid), 32'(m_pv));
        check("predict_state", 32'(predict_state), 32'(m_ps));
        check("predict", 32'(predict), 32'(m_ps[1]));
        check("q_count", 32'(q_count), 32'(mq_idx.size()));
        check("init_done", 32'(init_done), 32'(m_run));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic look(input logic [3:0] i);
        step(1'b0, 1'b1, i, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic upd(input logic [3:0] i, input logic t);
        step(1'b0, 1'b0, 4'd0, 1'b1, i, t);
    endtask

    initial begin
        int n;
        logic [1:0] exp2 [4];
        exp2[0] = 2'b01; exp2[1] = 2'b00; exp2[2] = 2'b00; exp2[3] = 2'b00;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("reset_pv", 32'(predict_valid), 32'd0);
        check("reset_qc", 32'(q_count), 32'd0);

        // Init length, with lookups and updates offered throughout (both ignored).
        n = 0;
        while (!init_done && n < 40) begin
            step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b1, 4'($urandom_range(0, 15)), 1'b1);
            n++;
        end
        check("init_cycles", 32'(n), 32'd16);

        look(4'd5);
        check("init_val_idx5", 32'(predict_state), 32'd2);
        check("init_pred_idx5", 32'(predict), 32'd1);

        for (int k = 0; k < 4; k++) begin
            upd(4'd3, 1'b0); idle(); idle(); look(4'd3);
            check("nt_sat_idx3", 32'(predict_state), 32'(exp2[k]));
        end
        upd(4'd3, 1'b1); idle(); idle(); look(4'd3);
        check("taken_idx3", 32'(predict_state), 32'd1);
        check("taken_pred_idx3", 32'(predict), 32'd0);

        for (int i = 0; i < 6; i++) upd(4'(8 + i), 1'(i));
        idle(); idle();
        for (int i = 0; i < 6; i++) look(4'(8 + i));

        upd(4'd7, 1'b1);
        look(4'd7);
`ifdef BPT_BYPASS_EN
        check("same_cycle_idx7", 32'(predict_state), 32'd3);
`else
        check("same_cycle_idx7", 32'(predict_state), 32'd2);
`endif
        look(4'd7);
        check("next_cycle_idx7", 32'(predict_state), 32'd3);

        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 9; i++) idle();
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("midinit_done", 32'(init_done), 32'd0);
        for (int i = 0; i < 16; i++) idle();
        upd(4'd12, 1'b1);
        check("qc_before_reset", 32'(q_count), 32'd1);
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("qc_after_reset", 32'(q_count), 32'd0);
        for (int i = 0; i < 16; i++) idle();
        look(4'd12);
        check("idx12_reinit", 32'(predict_state), 32'd2);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) == 0), 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
